mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 145 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: load alignment, cache-wait stall FSM with squash tracking, registered writeback.
// Optional misaligned-access trap enabled by defining MEM_WB_MISALIGN_TRAP_EN.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        flush,
    input  logic        data_read,
    input  logic        data_write,
    input  logic        load_regfile,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3_mem,
    input  logic [1:0]  addr_lsb,
    input  logic [31:0] alu_buffered,
    input  logic [31:0] data_rdata,
    input  logic        data_resp,
    output logic        stall_mem,
    output logic        wb_valid,
    output logic        wb_load_regfile,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [15:0] stall_cycles,
    output logic        misalign_trap
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT        = 2'd1,
        WAIT_SQUASH = 2'd2
    } state_t;

    state_t      state_r;
    logic        flush_pending_r;
    logic        access_s;
    logic        accept_s;
    logic        squash_s;
    logic        capture_s;
    logic        is_store_s;
    logic        misalign_s;
    logic        load_regfile_s;
    logic [31:0] result_s;

    function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                               input logic [1:0]  lsb,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lsb)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lsb[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  align_load = {{24{b[7]}}, b};
            3'b100:  align_load = {24'h00_0000, b};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b101:  align_load = {16'h0000, h};
            default: align_load = word;
        endcase
    endfunction

`ifdef MEM_WB_MISALIGN_TRAP_EN
    // Word accesses need addr_lsb=00, halfword accesses need an even address.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
        case (f3[1:0])
            2'b10:   is_misaligned = (lsb != 2'b00);
            2'b01:   is_misaligned = lsb[0];
            default: is_misaligned = 1'b0;
        endcase
    endfunction
`endif

    // Access/stall decode and next writeback values.
    always_comb begin
        access_s   = valid_in & (data_read | data_write) & ~flush_pending_r;
        stall_mem  = access_s & ~data_resp;
        accept_s   = valid_in & ~stall_mem;
        // A flushed wait keeps stalling but its result must never be written back.
        squash_s   = flush | flush_pending_r | (state_r == WAIT_SQUASH);
        capture_s  = accept_s & ~squash_s;
        is_store_s = data_write & ~data_read;
`ifdef MEM_WB_MISALIGN_TRAP_EN
        misalign_s = (data_read | data_write) & is_misaligned(funct3_mem, addr_lsb);
`else
        misalign_s = 1'b0;
`endif
        load_regfile_s = load_regfile & ~is_store_s & ~misalign_s;
        if (data_read) begin
            result_s = align_load(funct3_mem, addr_lsb, data_rdata);
        end else begin
            result_s = alu_buffered;
        end
    end

    // Stall FSM, saturating wait counter and registered writeback outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            flush_pending_r <= 1'b0;
            stall_cycles    <= 16'h0000;
            wb_valid        <= 1'b0;
            wb_load_regfile <= 1'b0;
            wb_rd           <= 5'd0;
            wb_data         <= 32'h0000_0000;
            misalign_trap   <= 1'b0;
        end else begin
            if (stall_mem && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end

            // Flush with an empty MEM slot squashes the instruction arriving next.
            if (accept_s) begin
                flush_pending_r <= 1'b0;
            end else if (flush && !valid_in) begin
                flush_pending_r <= 1'b1;
            end

            if (stall_mem) begin
                case (state_r)
                    IDLE:        state_r <= flush ? WAIT_SQUASH : WAIT;
                    WAIT:        state_r <= flush ? WAIT_SQUASH : WAIT;
                    WAIT_SQUASH: state_r <= WAIT_SQUASH;
                    default:     state_r <= IDLE;
                endcase
            end else begin
                state_r <= IDLE;
            end

            if (capture_s) begin
                wb_valid        <= 1'b1;
                wb_load_regfile <= load_regfile_s;
                wb_rd           <= rd;
                wb_data         <= result_s;
                misalign_trap   <= misalign_s;
            end else begin
                wb_valid        <= 1'b0;
                wb_load_regfile <= 1'b0;
                misalign_trap   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized instructions
// checked against a transaction-level reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, flush, data_read, data_write, load_regfile, data_resp;
    logic [4:0]  rd;
    logic [2:0]  funct3_mem;
    logic [1:0]  addr_lsb;
    logic [31:0] alu_buffered, data_rdata;
    logic        stall_mem, wb_valid, wb_load_regfile, misalign_trap;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [15:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic        exp_valid, exp_lr, exp_trap;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int          exp_cnt;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
        .data_read(data_read), .data_write(data_write), .load_regfile(load_regfile),
        .rd(rd), .funct3_mem(funct3_mem), .addr_lsb(addr_lsb),
        .alu_buffered(alu_buffered), .data_rdata(data_rdata), .data_resp(data_resp),
        .stall_mem(stall_mem), .wb_valid(wb_valid), .wb_load_regfile(wb_load_regfile),
        .wb_rd(wb_rd), .wb_data(wb_data), .stall_cycles(stall_cycles),
        .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input int f3, input int lsb, input logic [31:0] w);
        logic [31:0] v;
        if (f3 == 0 || f3 == 4) begin
            v = (w >> (8 * lsb)) & 32'h0000_00FF;
            if (f3 == 0 && v >= 32'd128) v = v - 32'd256;
        end else if (f3 == 1 || f3 == 5) begin
            v = (w >> ((lsb >= 2) ? 16 : 0)) & 32'h0000_FFFF;
            if (f3 == 1 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic model_misaligned(input int f3, input int lsb);
`ifdef MEM_WB_MISALIGN_TRAP_EN
        if (f3 == 2) return (lsb != 0);
        if (f3 == 1 || f3 == 5) return (lsb % 2 == 1);
        return 1'b0;
`else
        return (f3 < 0) && (lsb < 0);
`endif
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, exp_valid});
        check({tag, ".lr"},    {31'd0, wb_load_regfile}, {31'd0, exp_lr});
        check({tag, ".rd"},    {27'd0, wb_rd}, {27'd0, exp_rd});
        check({tag, ".data"},  wb_data, exp_data);
        check({tag, ".trap"},  {31'd0, misalign_trap}, {31'd0, exp_trap});
        check({tag, ".cnt"},   {16'd0, stall_cycles}, exp_cnt);
    endtask

    // One instruction held until completion; lat = cycles before data_resp, fl = flush cycle or -1.
    task automatic do_instr(input string tag, input logic rd_en, input logic wr_en, input logic lr,
                            input logic [4:0] r, input int f3, input int lsb,
                            input logic [31:0] alu, input logic [31:0] rdata,
                            input int lat_in, input int fl);
        int  lat;
        bit  squashed;
        bit  is_access;
        logic [2:0] f3v;
        logic [1:0] lsbv;
        f3v = f3[2:0];
        lsbv = lsb[1:0];
        is_access = rd_en | wr_en;
        lat = is_access ? lat_in : 0;
        squashed = 1'b0;
        valid_in = 1'b1; data_read = rd_en; data_write = wr_en; load_regfile = lr;
        rd = r; funct3_mem = f3v; addr_lsb = lsbv; alu_buffered = alu; data_rdata = rdata;
        for (int c = 0; c <= lat; c++) begin
            data_resp = (c == lat);
            flush = (c == fl);
            if (c == fl) squashed = 1'b1;
            @(negedge clk);
            check({tag, ".stall"}, {31'd0, stall_mem}, {31'd0, (is_access && c < lat)});
            @(posedge clk); #1;
            if (c < lat) begin
                if (exp_cnt < 65535) exp_cnt++;
                check({tag, ".waitvalid"}, {31'd0, wb_valid}, 32'd0);
            end
        end
        flush = 1'b0; data_resp = 1'b0;
        if (squashed) begin
            exp_valid = 1'b0; exp_lr = 1'b0; exp_trap = 1'b0;
        end else begin
            exp_valid = 1'b1;
            exp_rd = r;
            exp_data = rd_en ? model_load(f3, lsb, rdata) : alu;
            exp_trap = is_access && model_misaligned(f3, lsb);
            exp_lr = (rd_en || !wr_en) ? lr : 1'b0;
            if (exp_trap) exp_lr = 1'b0;
        end
        check_outputs(tag);
    endtask

    task automatic bubble(input string tag);
        valid_in = 1'b0; flush = 1'b0; data_resp = $urandom_range(0, 1);
        data_read = $urandom_range(0, 1); data_write = $urandom_range(0, 1);
        load_regfile = 1'b1; rd = 5'($urandom); alu_buffered = $urandom; data_rdata = $urandom;
        @(posedge clk); #1;
        exp_valid = 1'b0; exp_lr = 1'b0; exp_trap = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; flush = 1'b0; data_read = 1'b0; data_write = 1'b0;
        load_regfile = 1'b0; data_resp = 1'b0; rd = 5'd0; funct3_mem = 3'd0; addr_lsb = 2'd0;
        alu_buffered = 32'h0; data_rdata = 32'h0;
        exp_valid = 1'b0; exp_lr = 1'b0; exp_trap = 1'b0; exp_rd = 5'd0; exp_data = 32'h0; exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // lb at byte 3 of 0x80000000, immediate response
        do_instr("lb_sext", 1'b1, 1'b0, 1'b1, 5'd5, 0, 3, 32'h1111_1111, 32'h8000_0000, 0, -1);
        check("lb_const", wb_data, 32'hFFFF_FF80);
        // lhu upper half, 3 wait cycles
        do_instr("lhu_wait", 1'b1, 1'b0, 1'b1, 5'd6, 5, 2, 32'h2222_2222, 32'hBEEF_1234, 3, -1);
        check("lhu_const", wb_data, 32'h0000_BEEF);
        check("lhu_cnt", {16'd0, stall_cycles}, 32'd3);
        // lw flushed mid-wait: stall held until response, no writeback
        do_instr("lw_squash", 1'b1, 1'b0, 1'b1, 5'd7, 2, 0, 32'h3333_3333, 32'hCAFE_F00D, 4, 2);
        check("lw_squash_valid", {31'd0, wb_valid}, 32'd0);
        // misaligned lw
        do_instr("lw_mis", 1'b1, 1'b0, 1'b1, 5'd8, 2, 1, 32'h4444_4444, 32'h1234_5678, 1, -1);
`ifdef MEM_WB_MISALIGN_TRAP_EN
        check("lw_mis_trap", {31'd0, misalign_trap}, 32'd1);
        check("lw_mis_lr", {31'd0, wb_load_regfile}, 32'd0);
`else
        check("lw_mis_trap", {31'd0, misalign_trap}, 32'd0);
        check("lw_mis_data", wb_data, 32'h1234_5678);
`endif
        do_instr("store", 1'b0, 1'b1, 1'b1, 5'd9, 2, 0, 32'h5555_AAAA, 32'h0, 2, -1);
        do_instr("alu", 1'b0, 1'b0, 1'b1, 5'd10, 0, 0, 32'hDEAD_BEEF, 32'h0, 0, -1);
        do_instr("alu_flush", 1'b0, 1'b0, 1'b1, 5'd11, 0, 0, 32'h0BAD_0BAD, 32'h0, 0, 0);
        bubble("bubble0");

        // Reset pulse while waiting on the cache
        valid_in = 1'b1; data_read = 1'b1; data_write = 1'b0; funct3_mem = 3'd2; addr_lsb = 2'd0;
        data_resp = 1'b0; flush = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (exp_cnt < 65535) exp_cnt++;
        end
        check("rst_pre_stall", {31'd0, stall_mem}, 32'd1);
        rst = 1'b1;
        #1;
        exp_valid = 1'b0; exp_lr = 1'b0; exp_trap = 1'b0; exp_rd = 5'd0; exp_data = 32'h0; exp_cnt = 0;
        check_outputs("rst_mid");
        check("rst_stall_follows", {31'd0, stall_mem}, 32'd1);
        valid_in = 1'b0;
        #1;
        check("rst_stall_drop", {31'd0, stall_mem}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bubble("post_rst");
        do_instr("post_rst_lw", 1'b1, 1'b0, 1'b1, 5'd12, 2, 0, 32'h0, 32'h7654_3210, 1, -1);

        // Randomized instruction stream
        for (int i = 0; i < 250; i++) begin
            int kind, lat, fl;
            kind = $urandom_range(0, 2);
            lat = $urandom_range(0, 4);
            fl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat) : -1;
            do_instr("rand", kind == 1, kind == 2, 1'($urandom), 5'($urandom),
                     $urandom_range(0, 7), $urandom_range(0, 3), $urandom, $urandom, lat, fl);
            if ($urandom_range(0, 5) == 0) bubble("rand_bubble");
        end

        // Counter saturation: stall until just below the top, then past it
        valid_in = 1'b1; data_read = 1'b1; data_write = 1'b0; funct3_mem = 3'd2; addr_lsb = 2'd0;
        data_resp = 1'b0; flush = 1'b0; data_rdata = 32'h0F0F_0F0F; rd = 5'd3; load_regfile = 1'b1;
        while (exp_cnt < 65534) begin
            @(posedge clk);
            exp_cnt++;
        end
        #1;
        check("sat_fffe", {16'd0, stall_cycles}, 32'h0000_FFFE);
        repeat (5) @(posedge clk);
        #1;
        exp_cnt = 65535;
        check("sat_ffff", {16'd0, stall_cycles}, 32'h0000_FFFF);
        data_resp = 1'b1;
        @(posedge clk); #1;
        data_resp = 1'b0; valid_in = 1'b0;
        exp_valid = 1'b1; exp_lr = 1'b1; exp_rd = 5'd3; exp_data = 32'h0F0F_0F0F; exp_trap = 1'b0;
        check_outputs("sat_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
